// File: rtl/cksum_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share a single checksum
// engine. One request is serviced at a time: grant, start pulse, wait for
// the engine (bounded by TIMEOUT), then a one-hot completion pulse back to
// the grantee.

`ifndef ADDR_BUS
`define ADDR_BUS 16
`endif
`ifndef DATA_BUS
`define DATA_BUS 32
`endif
`ifndef HALF_BUS
`define HALF_BUS 16
`endif

module cksum_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 64,
   localparam int SEL_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_REQ-1:0]                   req_i,
   input  logic [NUM_REQ-1:0][`ADDR_BUS-1:0]    field_start_i,
   input  logic [NUM_REQ-1:0][`DATA_BUS-1:0]    field_len_i,
   output logic [SEL_W-1:0]                     sel_o,
   output logic                                 busy_o,
   output logic                                 eng_start_o,
   output logic [`ADDR_BUS-1:0]                 eng_field_start_o,
   output logic [`DATA_BUS-1:0]                 eng_field_len_o,
   input  logic                                 eng_ready_i,
   input  logic [`HALF_BUS-1:0]                 eng_val_i,
   output logic [NUM_REQ-1:0]                   done_o,
   output logic [`HALF_BUS-1:0]                 cksum_val_o,
   output logic                                 err_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // The wait is abandoned once the incremented count would reach this value,
   // so the grantee sees done_o exactly TIMEOUT cycles after the start pulse.
   localparam logic [8:0] EXPIRE = 9'(TIMEOUT - 1);

   state_t           state;
   state_t           state_next;
   logic [SEL_W-1:0] last_grant;
   logic [SEL_W-1:0] winner;
   logic [SEL_W-1:0] cand;
   logic             winner_found;
   logic [7:0]       cnt;
   logic             timeout_hit;

   assign timeout_hit = ({1'b0, cnt} + 9'd1) >= EXPIRE;

   // Round-robin search: first active request after the previous grantee,
   // wrapping naturally because NUM_REQ is a power of two.
   always_comb begin
      winner       = '0;
      winner_found = 1'b0;
      cand         = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = last_grant + SEL_W'(i);
         if (!winner_found && req_i[cand]) begin
            winner       = cand;
            winner_found = 1'b1;
         end
      end
   end

   // State register; reset drops any in-flight operation immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and the state-decoded outputs.
   always_comb begin
      state_next  = state;
      eng_start_o = 1'b0;
      busy_o      = 1'b0;
      done_o      = '0;
      case (state)
         IDLE: begin
            if (winner_found) begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            eng_start_o = 1'b1;
            busy_o      = 1'b1;
            state_next  = WAIT;
         end
         WAIT: begin
            busy_o = 1'b1;
            if (eng_ready_i || timeout_hit) begin
               state_next = RESP;
            end
         end
         RESP: begin
            busy_o = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
               done_o[i] = (sel_o == SEL_W'(i));
            end
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Grant capture, timeout counter, result latch and round-robin pointer.
   // eng_ready_i only matters in WAIT and beats a simultaneous timeout.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sel_o             <= '0;
         eng_field_start_o <= '0;
         eng_field_len_o   <= '0;
         cksum_val_o       <= '0;
         err_o             <= 1'b0;
         cnt               <= '0;
         last_grant        <= SEL_W'(NUM_REQ - 1);
      end else begin
         case (state)
            IDLE: begin
               if (winner_found) begin
                  sel_o             <= winner;
                  eng_field_start_o <= field_start_i[winner];
                  eng_field_len_o   <= field_len_i[winner];
                  err_o             <= 1'b0;
               end
            end
            ISSUE: begin
               cnt <= '0;
            end
            WAIT: begin
               if (eng_ready_i) begin
                  cksum_val_o <= eng_val_i;
                  err_o       <= 1'b0;
               end else if (timeout_hit) begin
                  cksum_val_o <= '0;
                  err_o       <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            RESP: begin
               last_grant <= sel_o;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cksum_arbiter.sv
// Self-checking bench for cksum_arbiter: expected completions are queued when
// the engine response is driven and compared when done_o pulses.

`ifndef ADDR_BUS
`define ADDR_BUS 16
`endif
`ifndef DATA_BUS
`define DATA_BUS 32
`endif
`ifndef HALF_BUS
`define HALF_BUS 16
`endif

module tb_cksum_arbiter;

   localparam int NREQ = 4;
   localparam int TOUT = 8;

   typedef struct packed {
      logic [NREQ-1:0]      done;
      logic [`HALF_BUS-1:0] val;
      logic                 err;
   } exp_t;

   logic                              clk = 1'b0;
   logic                              rst;
   logic [NREQ-1:0]                   req_i;
   logic [NREQ-1:0][`ADDR_BUS-1:0]    field_start_i;
   logic [NREQ-1:0][`DATA_BUS-1:0]    field_len_i;
   logic [1:0]                        sel_o;
   logic                              busy_o;
   logic                              eng_start_o;
   logic [`ADDR_BUS-1:0]              eng_field_start_o;
   logic [`DATA_BUS-1:0]              eng_field_len_o;
   logic                              eng_ready_i;
   logic [`HALF_BUS-1:0]              eng_val_i;
   logic [NREQ-1:0]                   done_o;
   logic [`HALF_BUS-1:0]              cksum_val_o;
   logic                              err_o;

   exp_t expQ[$];
   exp_t monE;
   int   checkCount = 0;
   int   passCount  = 0;
   int   cyc        = 0;
   int   doneSeen   = 0;
   int   lastDoneCyc = 0;

   cksum_arbiter #(.NUM_REQ(NREQ), .TIMEOUT(TOUT)) dut (
      .clk               (clk),
      .rst               (rst),
      .req_i             (req_i),
      .field_start_i     (field_start_i),
      .field_len_i       (field_len_i),
      .sel_o             (sel_o),
      .busy_o            (busy_o),
      .eng_start_o       (eng_start_o),
      .eng_field_start_o (eng_field_start_o),
      .eng_field_len_o   (eng_field_len_o),
      .eng_ready_i       (eng_ready_i),
      .eng_val_i         (eng_val_i),
      .done_o            (done_o),
      .cksum_val_o       (cksum_val_o),
      .err_o             (err_o)
   );

   // Free-running clock and cycle counter.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checkCount++;
      if (obs === expv) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   // Completion monitor: every done_o pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (rst === 1'b1 && done_o !== '0) begin
         doneSeen++;
         lastDoneCyc = cyc;
         if (expQ.size() == 0) begin
            checkOutput("unexpectedDone", 32'(done_o), 32'd0);
         end else begin
            monE = expQ.pop_front();
            checkOutput("doneVec", 32'(done_o), 32'(monE.done));
            checkOutput("cksumVal", 32'(cksum_val_o), 32'(monE.val));
            checkOutput("errFlag", 32'(err_o), 32'(monE.err));
         end
      end
   end

   task automatic applyStimulus(input logic [NREQ-1:0] req);
      req_i = req;
   endtask

   // Waits for the start pulse; returns at the negedge of the ISSUE cycle.
   task automatic waitStart(output int startCyc);
      bit ok = 1'b0;
      startCyc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (eng_start_o === 1'b1) begin
            ok = 1'b1;
            startCyc = cyc;
            break;
         end
      end
      checkOutput("startSeen", 32'(ok), 32'd1);
      checkOutput("busyAtStart", 32'(busy_o), 32'd1);
   endtask

   // Queues the expected completion and plays the engine side.
   task automatic serviceGrant(input int expSel, input int delay,
                               input logic [`HALF_BUS-1:0] val, input logic expErr);
      exp_t e;
      e.done = 4'(1 << expSel);
      e.val  = expErr ? '0 : val;
      e.err  = expErr;
      expQ.push_back(e);
      if (!expErr) begin
         repeat (delay) @(posedge clk);
         #1;
         eng_ready_i = 1'b1;
         eng_val_i   = val;
         @(posedge clk);
         #1;
         eng_ready_i = 1'b0;
         eng_val_i   = 16'hDEAD;
      end
   endtask

   // Waits (bounded) for the next done_o pulse seen by the monitor.
   task automatic waitDone();
      int n0 = doneSeen;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (doneSeen != n0) break;
      end
      checkOutput("doneCount", 32'(doneSeen - n0), 32'd1);
   endtask

   initial begin
      int s;
      int reqCyc;
      int n0;
      int order[5] = '{0, 1, 2, 3, 0};

      rst          = 1'b0;
      req_i        = '0;
      eng_ready_i  = 1'b0;
      eng_val_i    = 16'hDEAD;
      for (int i = 0; i < NREQ; i++) begin
         field_start_i[i] = 16'(10 + 2 * i);
         field_len_i[i]   = 32'(18 + i);
      end

      // Reset values.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstBusy", 32'(busy_o), 32'd0);
      checkOutput("rstSel", 32'(sel_o), 32'd0);
      checkOutput("rstDone", 32'(done_o), 32'd0);
      checkOutput("rstStart", 32'(eng_start_o), 32'd0);
      checkOutput("rstErr", 32'(err_o), 32'd0);
      checkOutput("rstVal", 32'(cksum_val_o), 32'd0);
      checkOutput("rstFStart", 32'(eng_field_start_o), 32'd0);
      checkOutput("rstFLen", eng_field_len_o, 32'd0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Contention: all four held, grants rotate 0,1,2,3,0.
      applyStimulus(4'b1111);
      for (int n = 0; n < 5; n++) begin
         waitStart(s);
         checkOutput($sformatf("rrSel%0d", n), 32'(sel_o), 32'(order[n]));
         checkOutput($sformatf("rrFStart%0d", n), 32'(eng_field_start_o), 32'(10 + 2 * order[n]));
         checkOutput($sformatf("rrFLen%0d", n), eng_field_len_o, 32'(18 + order[n]));
         serviceGrant(order[n], 2, 16'(16'h1000 + n), 1'b0);
         waitDone();
         checkOutput($sformatf("rrLatency%0d", n), 32'(lastDoneCyc - s), 32'd3);
      end
      applyStimulus(4'b0000);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("idleBusy", 32'(busy_o), 32'd0);

      // Single request from requester 2, engine ready 5 cycles after start.
      @(posedge clk);
      #1;
      applyStimulus(4'b0100);
      reqCyc = cyc;
      waitStart(s);
      checkOutput("singleStartLat", 32'(s - reqCyc), 32'd1);
      checkOutput("singleSel", 32'(sel_o), 32'd2);
      checkOutput("singleFStart", 32'(eng_field_start_o), 32'd14);
      checkOutput("singleFLen", eng_field_len_o, 32'd20);
      serviceGrant(2, 5, 16'hBEEF, 1'b0);
      checkOutput("singleStableSel", 32'(sel_o), 32'd2);
      waitDone();
      applyStimulus(4'b0000);
      checkOutput("singleDoneLat", 32'(lastDoneCyc - reqCyc), 32'd7);

      // Timeout: engine never answers.
      repeat (2) @(posedge clk);
      #1;
      applyStimulus(4'b0001);
      waitStart(s);
      serviceGrant(0, 0, 16'h0, 1'b1);
      waitDone();
      applyStimulus(4'b0000);
      checkOutput("timeoutLat", 32'(lastDoneCyc - s), 32'(TOUT));

      // Ready arriving on the final timeout cycle wins.
      repeat (2) @(posedge clk);
      #1;
      applyStimulus(4'b0001);
      waitStart(s);
      serviceGrant(0, TOUT - 1, 16'h5A5A, 1'b0);
      waitDone();
      applyStimulus(4'b0000);
      checkOutput("tieLat", 32'(lastDoneCyc - s), 32'(TOUT));

      // Stray ready while idle must be ignored.
      repeat (2) @(posedge clk);
      #1;
      n0 = doneSeen;
      eng_ready_i = 1'b1;
      eng_val_i   = 16'h1234;
      @(posedge clk);
      #1;
      eng_ready_i = 1'b0;
      eng_val_i   = 16'hDEAD;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("strayDone", 32'(doneSeen - n0), 32'd0);
      checkOutput("strayBusy", 32'(busy_o), 32'd0);
      checkOutput("strayVal", 32'(cksum_val_o), 32'h5A5A);

      // Reset in the middle of WAIT, then a fresh request from requester 1.
      applyStimulus(4'b0100);
      waitStart(s);
      checkOutput("midSel", 32'(sel_o), 32'd2);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("midBusy", 32'(busy_o), 32'd0);
      checkOutput("midDone", 32'(done_o), 32'd0);
      checkOutput("midStart", 32'(eng_start_o), 32'd0);
      checkOutput("midSelRst", 32'(sel_o), 32'd0);
      checkOutput("midFStart", 32'(eng_field_start_o), 32'd0);
      checkOutput("midFLen", eng_field_len_o, 32'd0);
      checkOutput("midVal", 32'(cksum_val_o), 32'd0);
      checkOutput("midErr", 32'(err_o), 32'd0);
      applyStimulus(4'b0010);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      waitStart(s);
      checkOutput("postRstSel", 32'(sel_o), 32'd1);
      checkOutput("postRstFStart", 32'(eng_field_start_o), 32'd12);
      serviceGrant(1, 3, 16'hC0DE, 1'b0);
      waitDone();
      applyStimulus(4'b0000);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/cksum_arbiter.md
CKSUM_ARBITER -- requirements
Module: cksum_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one cksum engine (power of 2, 2..8).
REQ-002 Parameter TIMEOUT, default 64: maximum cycles to wait for engine ready before abort (1..255).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_i  input  NUM_REQ  per-requester checksum request level; held high until matching done_o.
REQ-006 field_start_i  input  NUM_REQ x `ADDR_BUS  per-requester header offset of checksummed field.
REQ-007 field_len_i  input  NUM_REQ x `DATA_BUS  per-requester field length in bytes.
REQ-008 sel_o  output  log2(NUM_REQ)  index of granted requester; drives the external header-array mux feeding the engine.
REQ-009 busy_o  output  1  high while a grant is active (ISSUE/WAIT/RESP).
REQ-010 eng_start_o  output  1  one-cycle start pulse to engine.
REQ-011 eng_field_start_o  output  `ADDR_BUS  latched field_start of grantee.
REQ-012 eng_field_len_o  output  `DATA_BUS  latched field_len of grantee.
REQ-013 eng_ready_i  input  1  engine completion strobe.
REQ-014 eng_val_i  input  `HALF_BUS  engine result, valid with eng_ready_i.
REQ-015 done_o  output  NUM_REQ  one-hot, one-cycle completion pulse to grantee.
REQ-016 cksum_val_o  output  `HALF_BUS  result, valid with done_o.
REQ-017 err_o  output  1  high with done_o when operation timed out.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: if any req_i bit high, SHALL pick winner round-robin starting at (last_grant+1) mod NUM_REQ, register sel_o, eng_field_start_o, eng_field_len_o from winner, go ISSUE; else stay.
REQ-020 ISSUE: eng_start_o SHALL be 1 for exactly this cycle; timeout counter cleared to 0; go WAIT.
REQ-021 WAIT: on eng_ready_i, SHALL latch eng_val_i into cksum_val_o, err_o=0, go RESP.
REQ-022 WAIT: counter increments per cycle without eng_ready_i; when counter reaches TIMEOUT-1 without ready, SHALL set cksum_val_o=0, err_o=1, go RESP.
REQ-023 RESP: done_o[sel_o] SHALL be 1 for exactly this cycle; last_grant <= sel_o; go IDLE.
REQ-024 Latency: req_i rising in IDLE at cycle 0 -> eng_start_o at cycle 1; eng_ready_i at cycle k -> done_o at cycle k+1.
REQ-025 eng_ready_i outside WAIT SHALL be ignored.
REQ-026 eng_ready_i in the same cycle the counter expires SHALL take priority (err_o=0, real value).
REQ-027 req_i deasserted by grantee during WAIT SHALL NOT abort; done_o still pulses.
REQ-028 New requests during ISSUE/WAIT/RESP SHALL wait; next arbitration in the IDLE cycle after RESP (minimum 4-cycle grant period).
REQ-029 sel_o and eng_field_* SHALL stay stable from IDLE exit until RESP exit.
REQ-030 Pointer wrap: last_grant=NUM_REQ-1 -> search starts at 0.
REQ-031 No requester SHALL be granted twice while another held req_i continuously (starvation-free).

Reset
REQ-032 rst low SHALL immediately (asynchronously) force state IDLE, done_o=0, eng_start_o=0, busy_o=0, err_o=0, sel_o=0, cksum_val_o=0, eng_field_start_o=0, eng_field_len_o=0, counter=0, last_grant=NUM_REQ-1 (first grant favours index 0).
REQ-033 Reset mid-operation SHALL drop the operation with no done_o; pending requesters re-arbitrate after rst returns high.

Verification
REQ-034 Single: req_i=0100, start=14, len=20, eng_ready_i 5 cycles after start -> eng_start_o cycle 1, sel_o=2, eng_field_start_o=14, eng_field_len_o=20, done_o=0100 cycle 7 with cksum_val_o=eng_val_i, err_o=0.
REQ-035 Contention: req_i=1111 held, engine ready 2 cycles after each start -> grant order 0,1,2,3,0.
REQ-036 Timeout: req_i=0001, eng_ready_i never -> done_o=0001, err_o=1, cksum_val_o=0 exactly TIMEOUT cycles after eng_start_o cycle.
REQ-037 Tie: eng_ready_i on final timeout cycle -> err_o=0, value latched.
REQ-038 Mid-op reset: rst low during WAIT -> all outputs 0 same cycle, no done_o; after release with req_i=0010 held -> sel_o=1 grant.
REQ-039 Stray: eng_ready_i pulsed in IDLE -> no done_o, state unchanged.
